eth_tx_framer: RTL and testbench
================================

Name: eth_tx_framer

Overview:
Parametrised Ethernet II transmit framer and the successor to the fixed-header MAC serializer. It buffers one payload of 32-bit words, then emits a byte stream: preamble, SFD, destination MAC, source MAC, EtherType, payload, zero padding to the minimum payload, a computed CRC-32 FCS, and an inter-frame gap. It sits between the game-protocol packetizer and the PHY-side byte interface. Downstream backpressure is supported through a valid/ready handshake.

Parameters:
MAX_WORDS, 16, payload buffer depth in 32-bit words (≥1); maximum payload is 4*MAX_WORDS bytes
MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded
SRC_MAC, 48'h000A35C70000, source address, sent MSB byte first
DST_MAC, 48'h000A35C60000, destination address, sent MSB byte first
ETH_TYPE, 16'h6969, EtherType, sent MSB byte first
IFG_CYCLES, 12, idle cycles after the last FCS byte before the next frame may start

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
data_in  in  32  payload word; bits[31:24] are sent first
dval_in  in  1  data_in valid
last_in  in  1  qualifies the final payload word of the frame (sampled with dval_in)
in_ready  out  1  framer accepts a word this cycle
tx_data  out  8  output byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  downstream accepts the byte
tx_sof  out  1  high with the first preamble byte
tx_eof  out  1  high with the last FCS byte
busy  out  1  high in any state other than IDLE/LOAD

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; word count=0; CRC=32'hFFFFFFFF. All outputs are 0 except in_ready, which is 1.
- Word transfer occurs when dval_in && in_ready. in_ready=1 only in IDLE/LOAD with count<MAX_WORDS.
- IDLE: the first accepted word goes to LOAD.
- LOAD: each transfer writes buffer[count] and increments count. The frame closes on last_in, or when count reaches MAX_WORDS (forced last). On close, go to PREAMBLE on the next cycle. A transfer in IDLE carrying last_in also closes the frame (1-word payload).
- Byte transfer occurs when tx_valid && tx_ready. tx_valid=1 in PREAMBLE through FCS. tx_data and the sof/eof flags are held stable while stalled.
- PREAMBLE: 7 × 8'h55, with tx_sof on the first byte. Then SFD: 8'hD5.
- HEADER: 14 bytes (DST_MAC, SRC_MAC, ETH_TYPE). Then PAYLOAD: 4*count bytes in buffer order. Then PAD: max(0, MIN_PAYLOAD−4*count) bytes of 8'h00.
- CRC-32 (reflected, polynomial 32'hEDB88320, LSB-first per byte):
  - Initialised to 32'hFFFFFFFF at SFD.
  - Updated on each transferred HEADER/PAYLOAD/PAD byte only.
- FCS: 4 bytes of ~crc, sent crc[7:0] first. tx_eof is on the 4th byte. Then IFG.
- IFG: counts IFG_CYCLES cycles regardless of tx_ready, with in_ready=0. It then clears count and returns to IDLE. Input words are never accepted during a frame; there is single-frame buffering.
- Byte counter width: clog2(max(14, 4*MAX_WORDS, MIN_PAYLOAD, IFG_CYCLES))+1.
- Reset mid-frame aborts immediately with no eof. The next frame starts cleanly.
- tx_ready held low indefinitely: the state is frozen. No bytes are lost or duplicated.

Decomposition:
- eth_pkg:
  - state_t enum: IDLE, LOAD, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, IFG.
  - Constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3, HDR_BYTES=14.
- Sub-module eth_crc32: a registered byte-wise CRC with clear/enable/data inputs and crc output. It is reused by the future RX checker.

Test Plan:
- One-word payload 32'hDEADBEEF with last_in, tx_ready=1 → 72 bytes total:
  - 55×7, D5, 00 0A 35 C6 00 00, 00 0A 35 C7 00 00, 69 69, DE AD BE EF, 42×00, then 4 FCS bytes.
  - tx_sof on byte 1, tx_eof on byte 72.
  - Running the CRC over bytes 9–72 gives CRC_RESIDUE.
- 16-word payload with no last_in → forced close at word 16, in_ready=0 after it. 64 payload bytes, 0 pad, 90 bytes total.
- Toggle tx_ready randomly during the 12-word frame → output byte sequence identical to the tx_ready=1 run. tx_data is stable during stalls.
- Back-to-back frames, second dval_in asserted during FCS → in_ready=0 until exactly 12 cycles after the eof byte. Second frame's sof follows its LOAD close by 1 cycle.
- rst_n pulsed low during PAYLOAD → outputs zero asynchronously, in_ready=1. The next 1-word frame matches scenario 1 byte-for-byte.
- Payload of 11 words (44 bytes) → exactly 2 pad bytes and a correct FCS.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet framing types, constants and the byte-wise CRC-32 step
// used by the transmit framer and the future receive checker.
package eth_pkg;
    typedef enum logic [3:0] {
        IDLE, LOAD, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, IFG
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
    localparam int          HDR_BYTES     = 14;

    function automatic int imax(input int a, input int b);
        return a > b ? a : b;
    endfunction

    // Reflected CRC-32 advanced by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC_POLY : c >> 1;
        return c;
    endfunction
endpackage

// File: rtl/eth_crc32.sv
// eth_crc32: registered byte-wise reflected CRC-32 with synchronous clear and enable.
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc <= CRC_INIT;
        else if (clr) crc <= CRC_INIT;
        else if (en) crc <= crc32_byte(crc, data);
    end
endmodule

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: Ethernet II transmit framer; buffers one payload, then streams
// preamble, SFD, header, payload, zero pad, FCS and holds off for the inter-frame gap.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int          MAX_WORDS   = 16,
    parameter int          MIN_PAYLOAD = 46,
    parameter logic [47:0] SRC_MAC     = 48'h000A35C70000,
    parameter logic [47:0] DST_MAC     = 48'h000A35C60000,
    parameter logic [15:0] ETH_TYPE    = 16'h6969,
    parameter int          IFG_CYCLES  = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        dval_in,
    input  logic        last_in,
    output logic        in_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        busy
);
    localparam int BW = $clog2(imax(imax(HDR_BYTES, 4 * MAX_WORDS), imax(MIN_PAYLOAD, IFG_CYCLES))) + 1;
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int AW = MAX_WORDS > 1 ? $clog2(MAX_WORDS) : 1;
    localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETH_TYPE};

    state_t        state, nxt;
    logic [CW-1:0] count;
    logic [BW-1:0] cnt, pay_bytes, pad_bytes;
    logic [31:0]   buffer [MAX_WORDS];
    logic [31:0]   word, crc, fcs;
    logic          in_fire, tx_fire, seg_end, pad_needed, crc_en;

    assign in_ready   = (state == IDLE || state == LOAD) && count < CW'(MAX_WORDS);
    assign busy       = !(state == IDLE || state == LOAD);
    assign tx_valid   = busy && state != IFG;
    assign tx_sof     = state == PREAMBLE && cnt == '0;
    assign tx_eof     = state == FCS && cnt == BW'(3);
    assign in_fire    = dval_in && in_ready;
    assign tx_fire    = tx_valid && tx_ready;
    assign pay_bytes  = BW'({count, 2'b00});
    assign pad_needed = pay_bytes < BW'(MIN_PAYLOAD);
    assign pad_bytes  = BW'(MIN_PAYLOAD) - pay_bytes;
    assign word       = buffer[AW'(cnt >> 2)];
    assign fcs        = ~crc;
    assign crc_en     = tx_fire && (state == HEADER || state == PAYLOAD || state == PAD);

    // cnt indexes the byte within the current segment; seg_end marks its last byte.
    always_comb begin
        tx_data = 8'h00;
        seg_end = 1'b0;
        nxt     = state;
        case (state)
            PREAMBLE: begin tx_data = PREAMBLE_BYTE; seg_end = cnt == BW'(6); nxt = SFD; end
            SFD:      begin tx_data = SFD_BYTE; seg_end = 1'b1; nxt = HEADER; end
            HEADER:   begin tx_data = 8'(HDR >> {BW'(HDR_BYTES - 1) - cnt, 3'b000}); seg_end = cnt == BW'(HDR_BYTES - 1); nxt = PAYLOAD; end
            PAYLOAD:  begin tx_data = 8'(word >> {~cnt[1:0], 3'b000}); seg_end = cnt == pay_bytes - 1'b1; nxt = pad_needed ? PAD : FCS; end
            PAD:      begin seg_end = cnt == pad_bytes - 1'b1; nxt = FCS; end
            FCS:      begin tx_data = 8'(fcs >> {cnt[1:0], 3'b000}); seg_end = cnt == BW'(3); nxt = IFG; end
            IFG:      begin seg_end = cnt == BW'(IFG_CYCLES - 1); nxt = IDLE; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            cnt   <= '0;
        end else if (in_fire) begin
            count <= count + 1'b1;
            state <= (last_in || count == CW'(MAX_WORDS - 1)) ? PREAMBLE : LOAD;
            cnt   <= '0;
        end else if (tx_fire || state == IFG) begin
            cnt   <= seg_end ? '0 : cnt + 1'b1;
            state <= seg_end ? nxt : state;
            count <= (state == IFG && seg_end) ? '0 : count;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) buffer[AW'(count)] <= data_in;
    end

    eth_crc32 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == SFD),
        .en    (crc_en),
        .data  (tx_data),
        .crc   (crc)
    );
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: scoreboard bench; a frame model queues expected bytes, a monitor
// pops and compares every transferred byte and checks stalls, residue and gap timing.
module tb_eth_tx_framer;
    logic        clk = 0, rst_n = 1;
    logic [31:0] data_in = '0;
    logic        dval_in = 0, last_in = 0, tx_ready = 1;
    logic        in_ready, tx_valid, tx_sof, tx_eof, busy;
    logic [7:0]  tx_data;

    int          vectors = 0, miscompares = 0;
    int          cyc = 0;
    logic [9:0]  exp_q[$];
    logic [31:0] words[$];
    bit          rand_rdy = 0;
    int          mon_idx = 0, eof_cyc = 0;
    logic [31:0] rc = '0;
    bit          prev_stall = 0, wait_ifg = 0;
    logic [9:0]  prev_v = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    eth_tx_framer dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dval_in(dval_in), .last_in(last_in),
        .in_ready(in_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] tb_crc(input logic [31:0] c, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            logic b;
            b = c[0] ^ d[i];
            c = c >> 1;
            if (b) c ^= 32'hEDB88320;
        end
        return c;
    endfunction

    // Reference frame built straight from the Ethernet II layout.
    function automatic void push_frame();
        logic [7:0]   f[$];
        logic [111:0] hdr;
        logic [31:0]  c, w;
        int           n;
        hdr = {48'h000A35C60000, 48'h000A35C70000, 16'h6969};
        n = words.size() > 16 ? 16 : words.size();
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 0; i < 14; i++) f.push_back(hdr[111 - 8 * i -: 8]);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 3; k >= 0; k--) f.push_back(w[8 * k +: 8]);
        end
        while (f.size() < 8 + 14 + 46) f.push_back(8'h00);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < f.size(); i++) c = tb_crc(c, f[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) f.push_back(c[8 * k +: 8]);
        for (int i = 0; i < f.size(); i++) exp_q.push_back({i == 0, i == f.size() - 1, f[i]});
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1 tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
                wait_ifg = 0;
                mon_idx = 0;
                continue;
            end
            if (prev_stall) check("stall_hold", {22'h0, tx_sof, tx_eof, tx_data}, {22'h0, prev_v});
            if (wait_ifg && in_ready) begin
                check("ifg_cycles", cyc, eof_cyc + 13);
                wait_ifg = 0;
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_byte: got %h expected none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", {22'h0, tx_sof, tx_eof, tx_data}, {22'h0, e});
                end
                if (tx_sof) mon_idx = 0;
                if (mon_idx == 8) rc = 32'hFFFFFFFF;
                if (mon_idx >= 8) rc = tb_crc(rc, tx_data);
                mon_idx++;
                if (tx_eof) begin
                    check("fcs_residue", rc, 32'hDEBB20E3);
                    wait_ifg = 1;
                    eof_cyc = cyc;
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_v = {tx_sof, tx_eof, tx_data};
        end
    end

    task automatic send_frame(input bit use_last);
        @(posedge clk);
        #1;
        for (int i = 0; i < words.size(); i++) begin
            int t = 0;
            data_in = words[i];
            last_in = use_last && i == words.size() - 1;
            dval_in = 1;
            @(negedge clk);
            while (!in_ready && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                check("in_ready_timeout", 0, 1);
                dval_in = 0;
                last_in = 0;
                return;
            end
            @(posedge clk);
            #1;
        end
        dval_in = 0;
        last_in = 0;
        data_in = $urandom;
        @(negedge clk);
        check("sof_after_close", tx_sof, 1);
        check("in_ready_closed", in_ready, 0);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {tx_valid, tx_sof, tx_eof, busy, tx_data, in_ready}, 13'h1);
    endtask

    initial begin
        #1 rst_n = 0;
        #1 check_idle_outputs("reset_outputs");
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_hold");
        @(posedge clk);
        #1 rst_n = 1;

        words = {32'hDEADBEEF};
        push_frame();
        send_frame(1);
        drain();

        rand_words(16);
        push_frame();
        send_frame(0);
        drain();

        rand_rdy = 1;
        rand_words(12);
        push_frame();
        send_frame(1);
        drain();

        rand_rdy = 0;
        rand_words(5);
        push_frame();
        send_frame(1);
        rand_words(3);
        push_frame();
        send_frame(1);
        drain();

        rand_words(11);
        push_frame();
        send_frame(1);
        drain();

        rand_rdy = 1;
        for (int f = 0; f < 4; f++) begin
            int n = $urandom_range(1, 16);
            rand_words(n);
            push_frame();
            send_frame(n < 16 ? 1'b1 : 1'($urandom_range(0, 1)));
        end
        drain();

        rand_rdy = 0;
        rand_words(12);
        push_frame();
        mon_idx = 0;
        send_frame(1);
        begin
            int t = 0;
            while (mon_idx < 30 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            check("reach_payload", mon_idx >= 30, 1);
        end
        @(posedge clk);
        #3 rst_n = 0;
        exp_q.delete();
        #1 check_idle_outputs("async_reset_outputs");
        @(posedge clk);
        #1 rst_n = 1;
        words = {32'hDEADBEEF};
        push_frame();
        send_frame(1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
